// File: rtl/change_capture_pkg.sv
// Shared constants for the change-capture block.
// Data width and parameter defaults live here.
package change_capture_pkg;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] TERM_DEF = 8'hFF;
  localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Empty reads return zero; pointers wrap at DEPTH.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             do_push, do_pop;

  assign empty   = (fill_q == '0);
  assign full    = (fill_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when a pop frees the head slot.
  assign do_push = push && (!full || do_pop);
  assign fill    = fill_q;
  assign dout    = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) fill_d = fill_q + 1'b1;
    if (do_pop && !do_push) fill_d = fill_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && do_push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/change_capture.sv
// Captures samples whose bit 0 toggles into a FIFO
// until the terminal value is seen.
module change_capture
  import change_capture_pkg::*;
#(
  parameter int                DEPTH = DEPTH_DEF,
  parameter logic [DATA_W-1:0] TERM  = TERM_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
  output logic                   done
);
  logic [DATA_W-1:0] d1_q, d1_d;
  logic [DATA_W-1:0] d2_q, d2_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              change, push;
  logic              f_full, f_empty;

  assign change = d1_q[0] ^ d2_q[0];
  assign push   = change && !done_q;

  always_comb begin
    d1_d   = in_data;
    d2_d   = d1_q;
    ovf_d  = ovf_q;
    done_d = done_q;
    // Full with no pop: the sample is lost.
    if (push && f_full && !out_ready) ovf_d = 1'b1;
    if (d1_q == TERM) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      d1_q   <= '0;
      d2_q   <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (out_ready),
    .din   (d1_q),
    .dout  (out_data),
    .fill  (fill),
    .full  (f_full),
    .empty (f_empty)
  );

  assign out_valid = !f_empty;
  assign overflow  = ovf_q;
  assign done      = done_q;
endmodule

// File: tb/tb_change_capture.sv
// Bench for change_capture: queue model plus
// directed scenarios and random traffic.
module tb_change_capture;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rstn;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] fill;
  logic       overflow;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  change_capture #(.DEPTH(DEPTH), .TERM(8'hFF)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill      (fill),
    .overflow  (overflow),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: last two samples, a queue of captured bytes, two flags.
  logic [7:0] m1, m2;
  logic [7:0] mq[$];
  bit         movf, mdone, mon;
  bit         hold;
  logic [7:0] hdata;

  initial begin
    mon = 0;
    hold = 0;
  end

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      m1 = 8'h00;
      m2 = 8'h00;
      movf = 0;
      mdone = 0;
      hold = 0;
      mon = 1;
    end else if (mon) begin
      hold = out_valid && !out_ready;
      hdata = out_data;
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if ((m1[0] != m2[0]) && !mdone) begin
        if (mq.size() < DEPTH) mq.push_back(m1);
        else movf = 1;
      end
      if (m1 == 8'hFF) mdone = 1;
      m2 = m1;
      m1 = in_data;
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      logic [7:0] ed;
      ed = (mq.size() != 0) ? mq[0] : 8'h00;
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("fill", 32'(fill), 32'(mq.size()));
      chk("out_data", 32'(out_data), 32'(ed));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("done", 32'(done), 32'(mdone));
      if (hold) chk("stable", 32'(out_data), 32'(hdata));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    cyc(2);
    rstn = 1'b1;
  endtask

  initial begin
    int pops;
    rstn = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    cyc(1);
    do_reset();
    chk("rst_fill", 32'(fill), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // Hold then single step: one capture.
    in_data = 8'h10;
    cyc(4);
    in_data = 8'h11;
    cyc(4);
    chk("step_fill", 32'(fill), 1);
    chk("step_data", 32'(out_data), 32'h11);

    // Five events into a four-deep FIFO without draining.
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      in_data = 8'(v);
      cyc(1);
    end
    cyc(3);
    chk("ovf_fill", 32'(fill), 4);
    chk("ovf_flag", 32'(overflow), 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_order", 32'(out_data), 32'(k));
      cyc(1);
    end
    out_ready = 1'b0;
    chk("ovf_empty", 32'(fill), 0);

    // Full FIFO, push coincides with pop.
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      in_data = 8'(v);
      cyc(1);
    end
    cyc(3);
    chk("full_fill", 32'(fill), 4);
    in_data = 8'h05;
    cyc(1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(2);
    chk("fpp_fill", 32'(fill), 4);
    chk("fpp_ovf", 32'(overflow), 0);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("fpp_order", 32'(out_data), 32'(k));
      cyc(1);
    end
    out_ready = 1'b0;

    // Mid-run reset with entries and done set.
    do_reset();
    in_data = 8'h01;
    cyc(1);
    in_data = 8'h02;
    cyc(1);
    in_data = 8'hFF;
    cyc(3);
    chk("mr_fill", 32'(fill), 3);
    chk("mr_done", 32'(done), 1);
    rstn = 1'b0;
    cyc(1);
    chk("mr_fill0", 32'(fill), 0);
    chk("mr_valid0", 32'(out_valid), 0);
    chk("mr_done0", 32'(done), 0);
    chk("mr_ovf0", 32'(overflow), 0);
    rstn = 1'b1;
    in_data = 8'h01;
    cyc(3);
    chk("mr_resume", 32'(fill), 1);

    // Full count sweep with a free-running consumer.
    do_reset();
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      if (out_valid && out_ready) pops++;
      cyc(1);
    end
    chk("sweep_done1", 32'(done), 0);
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_ready) pops++;
      cyc(1);
      if (i == 0) chk("sweep_done2", 32'(done), 1);
    end
    chk("sweep_pops", 32'(pops), 255);
    chk("sweep_fill", 32'(fill), 0);

    // Random traffic and backpressure.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      in_data = 8'($urandom_range(0, 254));
      out_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    out_ready = 1'b1;
    cyc(6);
    chk("rand_drain", 32'(fill), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
